// File: rtl/mvm_uart_tx.sv
// mvm_uart_tx: serializes one R x W_Y_OUT result vector into BITS_PER_WORD-bit UART frames on tx.
// Latency: first start bit drives tx the cycle after the s_valid/s_ready handshake edge.
// Backpressure: s_ready is low for the whole vector; s_valid/s_data are ignored until IDLE returns.
module mvm_uart_tx #(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int BITS_PER_WORD    = 8,
  parameter int PACKET_SIZE_TX   = 13,
  parameter int W_Y_OUT          = 8,
  parameter int R                = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [R*W_Y_OUT-1:0]   s_data,
  output logic                   tx,
  output logic                   busy
);

  localparam int VW      = R * W_Y_OUT;
  localparam int N_WORDS = VW / BITS_PER_WORD;
  localparam int N_STOP  = PACKET_SIZE_TX - BITS_PER_WORD - 1;
  localparam int PW      = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
  localparam int BW      = (PACKET_SIZE_TX > 1) ? $clog2(PACKET_SIZE_TX) : 1;
  localparam int WW      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  localparam logic [PW-1:0] PULSE_LAST = PW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(PACKET_SIZE_TX - 1);
  localparam logic [WW-1:0] WORD_LAST  = WW'(N_WORDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          state;
  logic [PW-1:0]   pulse_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [WW-1:0]   word_cnt;
  // Low BITS_PER_WORD bits always hold the word currently on the wire.
  logic [VW-1:0]   data_q;

  logic                      pulse_wrap;
  logic                      bit_wrap;
  logic                      vec_done;
  logic [PW-1:0]             pulse_nxt;
  logic [BW-1:0]             bit_nxt;
  logic [WW-1:0]             word_nxt;
  logic [VW-1:0]             data_nxt;
  logic [PACKET_SIZE_TX-1:0] frame_nxt;
  logic                      tx_nxt;

  // Next counter values while sending, and the tx level the next cycle must carry.
  always_comb begin
    pulse_wrap = (pulse_cnt == PULSE_LAST);
    bit_wrap   = pulse_wrap && (bit_cnt == BIT_LAST);
    vec_done   = bit_wrap && (word_cnt == WORD_LAST);

    pulse_nxt  = pulse_wrap ? '0 : pulse_cnt + 1'b1;

    bit_nxt    = bit_cnt;
    if (pulse_wrap) begin
      bit_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    end

    word_nxt   = bit_wrap ? word_cnt + 1'b1 : word_cnt;

    // Move the next word into the low slot as the current frame's last stop bit ends.
    data_nxt   = bit_wrap ? (data_q >> BITS_PER_WORD) : data_q;

    // Frame image: start bit in position 0, data LSB first, stop bits on top.
    frame_nxt  = {{N_STOP{1'b1}}, data_nxt[BITS_PER_WORD-1:0], 1'b0};
    tx_nxt     = frame_nxt[bit_nxt];
  end

  // Control FSM: latch a vector in IDLE, then walk pulse/bit/word counters until the last stop bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      pulse_cnt <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      data_q    <= '0;
      tx        <= 1'b1;
      s_ready   <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (s_valid) begin
            data_q    <= s_data;
            pulse_cnt <= '0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            tx        <= 1'b0;
            state     <= SEND;
            s_ready   <= 1'b0;
            busy      <= 1'b1;
          end
        end
        SEND: begin
          if (vec_done) begin
            // One idle-high cycle minimum before the next vector's start bit.
            state     <= IDLE;
            pulse_cnt <= '0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            tx        <= 1'b1;
            s_ready   <= 1'b1;
            busy      <= 1'b0;
          end else begin
            pulse_cnt <= pulse_nxt;
            bit_cnt   <= bit_nxt;
            word_cnt  <= word_nxt;
            data_q    <= data_nxt;
            tx        <= tx_nxt;
          end
        end
        default: begin
          state   <= IDLE;
          tx      <= 1'b1;
          s_ready <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_uart_tx.sv
// Bench for mvm_uart_tx: default instance plus a CLOCKS_PER_PULSE=1, R=4 instance.
// Stimulus pushes expected bytes into per-instance queues; UART monitors decode tx and compare.
// Timing (start cycle, vector length, idle gap, handshake counts) is checked by the stimulus thread.
module tb_mvm_uart_tx;

  logic        clk = 1'b0;
  logic        rstn;
  logic        s_valid0, s_valid1;
  logic        rdy0, rdy1;
  logic [15:0] s_data0;
  logic [31:0] s_data1;
  logic        tx0, tx1;
  logic        busy0, busy1;

  always #5 clk = ~clk;

  mvm_uart_tx dut0 (
    .clk(clk), .rstn(rstn), .s_valid(s_valid0), .s_ready(rdy0),
    .s_data(s_data0), .tx(tx0), .busy(busy0)
  );

  mvm_uart_tx #(.CLOCKS_PER_PULSE(1), .BITS_PER_WORD(8), .PACKET_SIZE_TX(13),
                .W_Y_OUT(8), .R(4)) dut1 (
    .clk(clk), .rstn(rstn), .s_valid(s_valid1), .s_ready(rdy1),
    .s_data(s_data1), .tx(tx1), .busy(busy1)
  );

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int hs_cnt0 = 0, hs_cnt1 = 0;
  int hs_t0 = 0, hs_t1 = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int st0[$];
  int st1[$];

  // edge_n read at a negedge is the number of the cycle in progress.
  always @(posedge clk) edge_n <= edge_n + 1;

  always @(posedge clk) begin
    if (rstn && s_valid0 && rdy0) begin hs_cnt0 <= hs_cnt0 + 1; hs_t0 <= edge_n; end
    if (rstn && s_valid1 && rdy1) begin hs_cnt1 <= hs_cnt1 + 1; hs_t1 <= edge_n; end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic get_tx(input int which);
    return (which == 0) ? tx0 : tx1;
  endfunction

  // UART monitor: samples each cycle of a frame, checks the bit is held for cpp cycles, pops expectation.
  task automatic run_mon(input int which, input int ps, input int cpp);
    logic [15:0] got, expf;
    logic        bad, abrt, s;
    logic [7:0]  exp;
    int          qs;
    forever begin
      @(negedge clk);
      if (rstn && get_tx(which) == 1'b0) begin
        if (which == 0) st0.push_back(edge_n); else st1.push_back(edge_n);
        got = '0; bad = 1'b0; abrt = 1'b0;
        for (int k = 0; k < ps; k++) begin
          for (int j = 0; j < cpp; j++) begin
            if (k != 0 || j != 0) @(negedge clk);
            if (!rstn) abrt = 1'b1;
            s = get_tx(which);
            if (j == 0) got[k] = s;
            else if (s !== got[k]) bad = 1'b1;
          end
        end
        if (!abrt) begin
          qs = (which == 0) ? q0.size() : q1.size();
          if (qs == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_frame dut%0d actual=%0h required=no_frame", which, got);
          end else begin
            exp  = (which == 0) ? q0.pop_front() : q1.pop_front();
            expf = {7'b0, exp, 1'b0} | (~16'h01FF & ((16'd1 << ps) - 16'd1));
            chk($sformatf("frame_dut%0d", which), {bad, got}, {1'b0, expf});
          end
        end
      end
    end
  endtask

  initial run_mon(0, 13, 4);
  initial run_mon(1, 13, 1);

  task automatic wait_hs(input int which, input int prev, input int budget);
    int n = 0;
    while (((which == 0) ? hs_cnt0 : hs_cnt1) == prev && n < budget) begin
      @(negedge clk); n++;
    end
    if (((which == 0) ? hs_cnt0 : hs_cnt1) == prev) begin
      checks++; errors++;
      $display("FAIL hs_timeout dut%0d actual=none required=handshake", which);
    end
  endtask

  task automatic wait_ready(input int which, input int budget, output int cyc);
    cyc = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (((which == 0) ? rdy0 : rdy1) == 1'b1) begin cyc = edge_n; break; end
    end
  endtask

  // Send one vector on dut0 and verify start cycle and ready-return cycle.
  task automatic send0(input logic [15:0] d, input string tag);
    int prev, t, rc;
    st0.delete();
    prev = hs_cnt0;
    s_data0 = d; s_valid0 = 1'b1;
    q0.push_back(d[7:0]); q0.push_back(d[15:8]);
    wait_hs(0, prev, 20);
    s_valid0 = 1'b0;
    t = hs_t0;
    wait_ready(0, 300, rc);
    chk({tag, "_ready_cycle"}, rc, t + 105);
    chk({tag, "_start0"}, (st0.size() > 0) ? st0[0] : -1, t + 1);
    chk({tag, "_start1"}, (st0.size() > 1) ? st0[1] : -1, t + 53);
    chk({tag, "_hs_count"}, hs_cnt0 - prev, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_idle, prev, t1, t2, rc;
    rstn = 1'b0; s_valid0 = 1'b0; s_valid1 = 1'b0; s_data0 = '0; s_data1 = '0;

    // Reset values
    @(negedge clk);
    chk("rst_tx", tx0, 1'b1);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_ready", rdy0, 1'b1);
    chk("rst_tx_dut1", tx1, 1'b1);
    @(negedge clk);
    rstn = 1'b1;

    // Idle with s_valid low
    bad_idle = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || tx1 !== 1'b1) bad_idle++;
    end
    chk("idle_tx", bad_idle, 0);
    chk("idle_hs", hs_cnt0 + hs_cnt1, 0);

    // Single vector
    send0(16'h3CA5, "single");

    // Back-to-back with s_valid held high
    @(negedge clk);
    st0.delete();
    prev = hs_cnt0;
    s_data0 = 16'h00FF; s_valid0 = 1'b1;
    q0.push_back(8'hFF); q0.push_back(8'h00);
    wait_hs(0, prev, 20);
    t1 = hs_t0;
    s_data0 = 16'hFF00;
    q0.push_back(8'h00); q0.push_back(8'hFF);
    wait_hs(0, prev + 1, 200);
    t2 = hs_t0;
    s_valid0 = 1'b0;
    chk("b2b_second_hs", t2, t1 + 105);
    wait_ready(0, 300, rc);
    chk("b2b_ready", rc, t2 + 105);
    chk("b2b_hs_count", hs_cnt0 - prev, 2);
    chk("b2b_gap", (st0.size() > 2) ? st0[2] - st0[1] : -1, 53);

    // s_valid toggling and s_data changing while busy
    @(negedge clk);
    st0.delete();
    prev = hs_cnt0;
    s_data0 = 16'hC30F; s_valid0 = 1'b1;
    q0.push_back(8'h0F); q0.push_back(8'hC3);
    wait_hs(0, prev, 20);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      s_valid0 = 1'($urandom_range(0, 1));
      s_data0 = 16'($urandom);
    end
    s_valid0 = 1'b0;
    wait_ready(0, 300, rc);
    chk("busy_ignore_hs", hs_cnt0 - prev, 1);
    chk("busy_ignore_ready", rc, hs_t0 + 105);

    // Reset during data bit 3 of word 0 (word 0 = 0x00, so tx is low then)
    @(negedge clk);
    prev = hs_cnt0;
    s_data0 = 16'h5500; s_valid0 = 1'b1;
    q0.push_back(8'h00); q0.push_back(8'h55);
    wait_hs(0, prev, 20);
    s_valid0 = 1'b0;
    while (edge_n < hs_t0 + 18) @(negedge clk);
    chk("pre_rst_tx", tx0, 1'b0);
    #1 rstn = 1'b0;
    #1;
    chk("async_rst_tx", tx0, 1'b1);
    chk("async_rst_busy", busy0, 1'b0);
    q0.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", rdy0, 1'b1);
    repeat (60) @(negedge clk);
    send0(16'h1234, "after_rst");

    // CLOCKS_PER_PULSE=1, R=4 instance
    @(negedge clk);
    st1.delete();
    prev = hs_cnt1;
    s_data1 = 32'hDEADBEEF; s_valid1 = 1'b1;
    q1.push_back(8'hEF); q1.push_back(8'hBE); q1.push_back(8'hAD); q1.push_back(8'hDE);
    wait_hs(1, prev, 20);
    s_valid1 = 1'b0;
    wait_ready(1, 200, rc);
    chk("cpp1_ready", rc, hs_t1 + 53);
    chk("cpp1_start0", (st1.size() > 0) ? st1[0] : -1, hs_t1 + 1);
    chk("cpp1_start3", (st1.size() > 3) ? st1[3] : -1, hs_t1 + 40);

    repeat (20) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mvm_uart_tx.md
Name: mvm_uart_tx

Overview:
UART transmit end of the MVM UART system: the serializer that returns matrix-vector results to the host over the single tx pin. It accepts one result vector (R words of W_Y_OUT bits) from the MVM core through a valid/ready handshake. It slices the vector into BITS_PER_WORD-bit words and sends each as one PACKET_SIZE_TX-bit UART frame. It mirrors the frame format the system's UART receiver expects, so the host-side link is symmetric.

Parameters:
CLOCKS_PER_PULSE, 4, clk cycles per UART bit (baud divider); must be >= 1.
BITS_PER_WORD, 8, data bits per UART frame.
PACKET_SIZE_TX, 13, total bits per frame: 1 start + BITS_PER_WORD data + (PACKET_SIZE_TX-BITS_PER_WORD-1) stop bits; must be >= BITS_PER_WORD+2.
W_Y_OUT, 8, width of one result element; must be a multiple of BITS_PER_WORD.
R, 2, result elements per vector.
Derived: N_WORDS = R*W_Y_OUT/BITS_PER_WORD (2 at defaults).

Ports:
clk  in  1  system clock
rstn  in  1  reset; one clock, asynchronous assert, active-low
s_valid  in  1  result vector available from MVM core
s_ready  out  1  block can accept a vector
s_data  in  R*W_Y_OUT  result vector; element i at [i*W_Y_OUT +: W_Y_OUT]
tx  out  1  UART serial output, idle high, registered
busy  out  1  high while a vector is being transmitted

Behaviour:
- Reset values (asynchronous, on rstn=0): tx=1, busy=0, s_ready=1, state=IDLE, all counters 0, data register 0.
- States: IDLE and SEND.
- s_ready = (state==IDLE); busy = (state==SEND).
- IDLE: tx=1. On a clk edge with s_valid && s_ready:
  - latch s_data into the shift register; s_data may change afterwards.
  - clear pulse/bit/word counters; go to SEND.
- s_valid low in IDLE: nothing happens. s_valid may be held high indefinitely; no vector is dropped or duplicated.
- SEND bit timing:
  - Each bit is held on tx for exactly CLOCKS_PER_PULSE cycles.
  - The first start bit appears on tx in the cycle after the handshake edge.
- Frame contents, in bit order:
  - bit 0 = start bit (0).
  - bits 1..BITS_PER_WORD = data, LSB first.
  - remaining bits = stop bits (1).
- Word order: word 0 = s_data[BITS_PER_WORD-1:0] is sent first, then increasing word index. Element 0 therefore goes out first, low byte first within an element.
- Frames within one vector are back-to-back: the next start bit directly follows the last stop-bit cycle, with no idle gap.
- After the final stop bit of word N_WORDS-1: return to IDLE. s_ready=1 in that cycle, tx=1.
  - A vector accepted on that first IDLE edge starts its start bit one cycle later.
  - Minimum inter-vector idle-high time is therefore 1 cycle.
- Vector duration: N_WORDS*PACKET_SIZE_TX*CLOCKS_PER_PULSE cycles (104 at defaults), measured from first start-bit cycle to last stop-bit cycle inclusive.
- Counter widths: $clog2 of their ranges (min 1 bit). Pulse counter wraps CLOCKS_PER_PULSE-1 -> 0 and advances the bit counter. Bit counter wraps PACKET_SIZE_TX-1 -> 0 and advances the word counter.
- CLOCKS_PER_PULSE=1 must work: one bit per cycle.
- Reset mid-frame: tx returns to 1 immediately (asynchronously). The partial vector is discarded, and the block is ready (s_ready=1) on the first edge after rstn deasserts.
- s_valid while busy is ignored; s_data is not sampled.

Test Plan:
- Single vector, s_data=16'h3CA5, defaults: handshake at edge T -> tx=0 for cycles T+1..T+4; data bits 1,0,1,0,0,1,0,1 (4 cycles each); tx=1 for 16 cycles; then frame 0x3C; s_ready returns 1 at T+105.
- Idle/reset: rstn=0 with s_valid=0 -> tx=1, busy=0, s_ready=1; s_valid held low for 200 cycles -> tx stays 1.
- Back-to-back: s_valid held high with vectors 16'h00FF then 16'hFF00 -> bytes FF,00,00,FF decoded by a bench UART monitor; exactly 1 idle-high cycle between vectors; exactly 2 handshakes.
- Busy ignore: change s_data and toggle s_valid during SEND -> transmitted bytes still match the latched vector; no extra handshake.
- Reset mid-frame: assert rstn=0 during data bit 3 of word 0 -> tx=1 asynchronously. After release, vector 16'h1234 is sent cleanly as 34,12.
- Parameter sweep, CLOCKS_PER_PULSE=1, R=4: s_data=32'hDEADBEEF -> EF,BE,AD,DE; each bit held 1 cycle; 52 cycles total.
